// File: rtl/point_sprite_pkg.sv
// Shared types and constants for the 15x15 2-bpp point sprite memory.
// Provides sprite geometry, address/pixel types and the recolor FSM encoding.
// No ports; imported by point_sprite_ctrl and sprite_addr_calc.
package point_sprite_pkg;

  localparam int SPRITE_W = 15;
  localparam int SPRITE_H = 15;
  localparam int DEPTH    = SPRITE_W * SPRITE_H;
  localparam int AW       = 8;
  localparam int DW       = 2;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } recolor_state_t;

  // Last linear address visited by the recolor sweep.
  localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational (row, col) -> linear sprite address, row*15+col, plus in-range flag.
// Ports: row_i/col_i (4-bit pixel coordinates), addr_o (linear address),
//        in_range_o (1 when row < 15 and col < 15). Zero latency, no state.
module sprite_addr_calc
  import point_sprite_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output addr_t      addr_o,
  output logic       in_range_o
);

  addr_t row_w;
  addr_t col_w;

  assign row_w = {{(AW-4){1'b0}}, row_i};
  assign col_w = {{(AW-4){1'b0}}, col_i};

  // row*15 without a multiplier: row*16 - row.
  assign addr_o     = (row_w << 4) - row_w + col_w;
  assign in_range_o = (row_i < 4'(SPRITE_H)) && (col_i < 4'(SPRITE_W));

endmodule

// File: rtl/point_sprite_ctrl.sv
// Owns the sprite memory ports: display reads (priority, 1-cycle latency) and a
// background read-modify-write recolor sweep that only uses idle read cycles.
// Ports: Clk/Reset (sync, active-high); disp_* display request/response;
//        recolor_* sweep control, busy/done status; mem_* memory read/write ports.
// Build option POINT_SPRITE_RECOLOR_SWAP_EN: sweep swaps from<->to instead of
// a one-way from->to replace.
module point_sprite_ctrl
  import point_sprite_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       disp_req,
  input  logic [3:0] disp_col,
  input  logic [3:0] disp_row,
  output logic       disp_valid,
  output pixel_t     disp_pixel,
  input  logic       recolor_start,
  input  pixel_t     recolor_from,
  input  pixel_t     recolor_to,
  output logic       busy,
  output logic       done,
  output addr_t      mem_read_address,
  output addr_t      mem_write_address,
  output pixel_t     mem_data_In,
  output logic       mem_we,
  input  pixel_t     mem_data_Out
);

  recolor_state_t state_q, state_d;
  addr_t          cnt_q, cnt_d;
  pixel_t         from_q, from_d;
  pixel_t         to_q, to_d;
  logic           pend_vld_q;
  addr_t          pend_addr_q;
  logic           disp_vld_q;
  logic           disp_oob_q;

  addr_t          disp_addr;
  logic           disp_in_range;
  logic           sweep_rd;
  logic           hit_from;
  logic           hit_to;
  pixel_t         wr_data;

  sprite_addr_calc u_addr_calc (
    .row_i      (disp_row),
    .col_i      (disp_col),
    .addr_o     (disp_addr),
    .in_range_o (disp_in_range)
  );

  // The sweep only gets the read port when the display is silent, even if the
  // display request is out of range and issues no read itself.
  assign sweep_rd = (state_q == SCAN) && !disp_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    from_d  = from_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (recolor_start) begin
          state_d = SCAN;
          cnt_d   = '0;
          from_d  = recolor_from;
          to_d    = recolor_to;
        end
      end
      SCAN: begin
        if (sweep_rd) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end
        end
      end
      // No reads are issued here, so the final pending read completes its
      // (optional) write this cycle and the pending stage is empty afterwards.
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      from_q      <= '0;
      to_q        <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      disp_vld_q  <= 1'b0;
      disp_oob_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      from_q      <= from_d;
      to_q        <= to_d;
      pend_vld_q  <= sweep_rd;
      pend_addr_q <= cnt_q;
      disp_vld_q  <= disp_req;
      disp_oob_q  <= disp_req && !disp_in_range;
    end
  end

  always_comb begin
    mem_read_address = '0;
    if (disp_req) begin
      if (disp_in_range) begin
        mem_read_address = disp_addr;
      end
    end else if (sweep_rd) begin
      mem_read_address = cnt_q;
    end
  end

  assign hit_from = (mem_data_Out == from_q);
`ifdef POINT_SPRITE_RECOLOR_SWAP_EN
  assign hit_to  = (mem_data_Out == to_q);
  assign wr_data = hit_from ? to_q : from_q;
`else
  assign hit_to  = 1'b0;
  assign wr_data = to_q;
`endif

  // Write lags the sweep read by one cycle, so it never targets the address
  // the sweep is reading in the same cycle.
  assign mem_we            = pend_vld_q && (hit_from || hit_to);
  assign mem_write_address = mem_we ? pend_addr_q : '0;
  assign mem_data_In       = mem_we ? wr_data : '0;

  assign disp_valid = disp_vld_q;
  assign disp_pixel = (disp_vld_q && !disp_oob_q) ? mem_data_Out : '0;

  assign busy = (state_q == SCAN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule
